// File: rtl/trace_pkg.sv
// Shared definitions for the CPU trace capture buffer.
// Modes, FSM encoding and the default trace word layout.
package trace_pkg;

    localparam int TRC_TRACE_W  = 40;
    localparam int TRC_TRIG_LSB = 24;
    localparam int TRC_TRIG_W   = 16;

    // Mode 3 is reserved and falls through to ring behaviour.
    localparam logic [1:0] TRC_MODE_RING     = 2'd0;
    localparam logic [1:0] TRC_MODE_FULLSTOP = 2'd1;
    localparam logic [1:0] TRC_MODE_TRIG     = 2'd2;

    typedef enum logic [1:0] {
        TRC_IDLE  = 2'd0,
        TRC_ARMED = 2'd1,
        TRC_POST  = 2'd2,
        TRC_DONE  = 2'd3
    } trc_state_e;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port synchronous RAM, one write and one read port.
// Registered read data holds between reads; contents are not reset.
module trace_ram
    import trace_pkg::*;
#(
    parameter int  W     = TRC_TRACE_W,
    parameter int  DEPTH = 512,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset, which block RAMs support.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cpu_trace_buffer.sv
// CPU bus trace capture buffer: ring, stop-when-full and triggered modes,
// with masked address trigger, post-trigger count and FIFO readout.
module cpu_trace_buffer
    import trace_pkg::*;
#(
    parameter int  TRACE_W  = TRC_TRACE_W,
    parameter int  DEPTH    = 512,
    parameter int  TRIG_LSB = TRC_TRIG_LSB,
    parameter int  TRIG_W   = TRC_TRIG_W,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic               clk6x,
    input  logic               reset,
    input  logic [TRACE_W-1:0] trace_i,
    input  logic               trace_catch_i,
    input  logic               arm_i,
    input  logic               disarm_i,
    input  logic               clear_i,
    input  logic [1:0]         mode_i,
    input  logic [TRIG_W-1:0]  trig_value_i,
    input  logic [TRIG_W-1:0]  trig_mask_i,
    input  logic [AW:0]        post_count_i,
    input  logic               rd_pop_i,
    output logic [TRACE_W-1:0] rd_data_o,
    output logic               rd_valid_o,
    output logic [AW:0]        count_o,
    output logic               armed_o,
    output logic               triggered_o,
    output logic               overflow_o,
    output logic               done_o
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    trc_state_e    state_q;
    trc_state_e    state_d;
    logic [1:0]    mode_q;
    logic [AW:0]   post_q;
    logic [AW:0]   post_cnt_q;
    logic [AW:0]   count_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic          trig_q;
    logic          ovf_q;
    logic          rd_valid_q;

    logic capturing;
    logic full;
    logic hit;
    logic do_catch;
    logic do_pop;
    logic fire;
    logic flush;

    always_comb begin
        capturing = (state_q == TRC_ARMED) || (state_q == TRC_POST);
        full      = (count_q == CNT_FULL);
        hit       = ((trace_i[TRIG_LSB +: TRIG_W] ^ trig_value_i)
                     & trig_mask_i) == '0;
        flush     = clear_i || arm_i;
        do_catch  = trace_catch_i && capturing && !flush && !disarm_i
                    && !(mode_q == TRC_MODE_FULLSTOP && full);
        do_pop    = rd_pop_i && !capturing && !flush
                    && (count_q != '0);
        fire      = do_catch && (state_q == TRC_ARMED)
                    && (mode_q == TRC_MODE_TRIG) && hit;
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = TRC_IDLE;
        end else if (arm_i) begin
            state_d = TRC_ARMED;
        end else if (disarm_i && capturing) begin
            state_d = TRC_DONE;
        end else if (do_catch) begin
            if (mode_q == TRC_MODE_FULLSTOP && count_q == CNT_LAST) begin
                state_d = TRC_DONE;
            end else if (fire) begin
                state_d = (post_q == '0) ? TRC_DONE : TRC_POST;
            end else if (state_q == TRC_POST && post_cnt_q == CNT_ONE) begin
                state_d = TRC_DONE;
            end
        end
    end

    always_ff @(posedge clk6x) begin
        if (reset) begin
            state_q    <= TRC_IDLE;
            mode_q     <= TRC_MODE_RING;
            post_q     <= '0;
            post_cnt_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            trig_q     <= 1'b0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= do_pop;
            if (flush) begin
                count_q    <= '0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                post_cnt_q <= '0;
                trig_q     <= 1'b0;
                ovf_q      <= 1'b0;
                if (!clear_i) begin
                    mode_q <= mode_i;
                    post_q <= post_count_i;
                end
            end else begin
                if (do_catch) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    // A full ring drops its oldest entry to make room.
                    if (full) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        ovf_q    <= 1'b1;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end else if (do_pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    count_q  <= count_q - 1'b1;
                end
                if (fire) begin
                    trig_q     <= 1'b1;
                    post_cnt_q <= post_q;
                end else if (do_catch && state_q == TRC_POST) begin
                    post_cnt_q <= post_cnt_q - 1'b1;
                end
            end
        end
    end

    trace_ram #(
        .W     (TRACE_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk6x),
        .reset (reset),
        .we    (do_catch),
        .waddr (wr_ptr_q),
        .wdata (trace_i),
        .re    (do_pop),
        .raddr (rd_ptr_q),
        .rdata (rd_data_o)
    );

    assign rd_valid_o  = rd_valid_q;
    assign count_o     = count_q;
    assign armed_o     = capturing;
    assign triggered_o = trig_q;
    assign overflow_o  = ovf_q;
    assign done_o      = (state_q == TRC_DONE);

endmodule
